alu_seq: RTL and testbench

//  Parametrised, registered successor to the 16-bit combinational ALU in the SR-1 CPU datapath.
//  - Encoded opcode, valid/ready handshake on both sides, registered flags.
//  - Iterative shift-add multiplier producing a full 2*WIDTH product.
//  - SIMD-style lane mode for ADD/SUB. Sits between register-file read and writeback.

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake, SIMD lane ADD/SUB and an iterative multiplier
//   Ports: clk, rst_n (synchronous, active low); in_valid/in_ready request handshake;
//          op[3:0], lane_mode, a, b operands; out_valid/out_ready result handshake;
//          result, result_hi (MUL high half), flag_z/c/n/v, err (illegal or compiled-out op).
//   Build macro ALU_MULT_EN: defined adds the shift-add multiplier and MUL state;
//          undefined leaves op 2 illegal.
module alu_seq #(
   parameter int WIDTH  = 16,
   parameter int LANE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             lane_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v,
   output logic             err
);
   localparam int SHW = $clog2(WIDTH);
   localparam int NL  = WIDTH / LANE_W;
`ifdef ALU_MULT_EN
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
   typedef enum logic {IDLE, DONE} state_t;
`endif
   state_t state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
   logic z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, err_q, err_d;
   logic accept, is_mul, illegal, sub, lane_cy, alu_c, alu_v;
   logic [WIDTH-1:0] bx, sum, alu_res;
   logic [LANE_W:0] lane_sum;
   logic [SHW-1:0] amt;
   logic [WIDTH:0] shl_w, shr_w;
   logic signed [WIDTH:0] asr_w;
`ifdef ALU_MULT_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d, mul_next;
   logic [WIDTH:0] mul_up;
   logic [SHW-1:0] cnt_q, cnt_d;
   logic last;
   assign is_mul  = op == 4'd2;
   assign illegal = op > 4'd9;
   assign last    = cnt_q == SHW'(WIDTH - 1);
`else
   assign is_mul  = 1'b0;
   assign illegal = op > 4'd9 || op == 4'd2;
`endif
   assign accept = in_valid && in_ready;
   assign amt    = b[SHW-1:0];
   // Lanes form a ripple chain; in lane mode every lane restarts with the SUB carry-in,
   // so lane_cy ends as the carry of the top lane in both modes.
   always_comb begin
      sub      = op == 4'd1;
      bx       = sub ? ~b : b;
      lane_cy  = sub;
      sum      = '0;
      lane_sum = '0;
      for (int i = 0; i < NL; i++) begin
         lane_sum = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, bx[i*LANE_W +: LANE_W]}
                  + {{LANE_W{1'b0}}, lane_mode ? sub : lane_cy};
         sum[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
         lane_cy = lane_sum[LANE_W];
      end
      // Extra guard bit on each shifter catches the last bit shifted out (0 for amount 0).
      shl_w   = {1'b0, a} << amt;
      shr_w   = {a, 1'b0} >> amt;
      asr_w   = $signed({a, 1'b0}) >>> amt;
      alu_res = (op == 4'd0 || op == 4'd1) ? sum :
                op == 4'd3 ? a & b :
                op == 4'd4 ? a | b :
                op == 4'd5 ? a ^ b :
                op == 4'd6 ? ~a :
                op == 4'd7 ? shl_w[WIDTH-1:0] :
                op == 4'd8 ? shr_w[WIDTH:1] :
                op == 4'd9 ? asr_w[WIDTH:1] : '0;
      // Borrow is the inverted carry of a + ~b + 1.
      alu_c   = op <= 4'd1 ? lane_cy ^ sub :
                op == 4'd7 ? shl_w[WIDTH] :
                op == 4'd8 ? shr_w[0] :
                op == 4'd9 ? asr_w[0] : 1'b0;
      alu_v   = op <= 4'd1 && a[WIDTH-1] == bx[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
   end
   always_comb begin
`ifdef ALU_MULT_EN
      state_d = state_q == IDLE ? (accept ? (is_mul ? MUL : DONE) : IDLE) :
                state_q == MUL  ? (last ? DONE : MUL) :
                (out_ready ? IDLE : DONE);
`else
      state_d = state_q == IDLE ? (accept ? DONE : IDLE) : (out_ready ? IDLE : DONE);
`endif
   end
   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
   end
   always_comb begin
      result_d    = result_q;
      result_hi_d = result_hi_q;
      z_d         = z_q;
      c_d         = c_q;
      n_d         = n_q;
      v_d         = v_q;
      err_d       = err_q;
      if (accept && !is_mul) begin
         result_d    = alu_res;
         result_hi_d = '0;
         z_d         = !illegal && alu_res == '0;
         c_d         = alu_c;
         n_d         = alu_res[WIDTH-1];
         v_d         = alu_v;
         err_d       = illegal;
      end
`ifdef ALU_MULT_EN
      // Product register starts as {0, b}; each step adds the multiplicand into the upper
      // half when the current multiplier bit is set, then shifts right one place.
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      mul_up   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_up, prod_q[WIDTH-1:1]};
      if (accept && is_mul) begin
         mcand_d = a;
         prod_d  = {{WIDTH{1'b0}}, b};
         cnt_d   = '0;
      end
      if (state_q == MUL) begin
         prod_d = mul_next;
         cnt_d  = cnt_q + SHW'(1);
         if (last) begin
            result_d    = mul_next[WIDTH-1:0];
            result_hi_d = mul_next[2*WIDTH-1:WIDTH];
            z_d         = mul_next[WIDTH-1:0] == '0;
            c_d         = |mul_next[2*WIDTH-1:WIDTH];
            n_d         = mul_next[WIDTH-1];
            v_d         = 1'b0;
            err_d       = 1'b0;
         end
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         err_q       <= 1'b0;
`ifdef ALU_MULT_EN
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         z_q         <= z_d;
         c_q         <= c_d;
         n_q         <= n_d;
         v_q         <= v_d;
         err_q       <= err_d;
`ifdef ALU_MULT_EN
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
`endif
      end
   end
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign flag_n    = n_q;
   assign flag_v    = v_q;
   assign err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=16, LANE_W=8); MUL scenarios follow ALU_MULT_EN.
module tb_alu_seq;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, lane_mode = 1'b0, out_ready = 1'b1;
   logic [3:0] op = '0;
   logic [15:0] a = '0, b = '0;
   logic in_ready, out_valid, flag_z, flag_c, flag_n, flag_v, err;
   logic [15:0] result, result_hi;
   int checks = 0, passed = 0;
   // f packs the expected flags as {z, c, n, v, err}
   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        lm;
      logic [15:0] hi, res;
      logic [4:0]  f;
      int          lat;
   } vec_t;
   vec_t exp_q[$];
   alu_seq #(.WIDTH(16), .LANE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .lane_mode(lane_mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .flag_z(flag_z), .flag_c(flag_c),
      .flag_n(flag_n), .flag_v(flag_v), .err(err)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
      $fatal(1);
   end
   function automatic vec_t mk(logic [3:0] o, logic [15:0] x, logic [15:0] y, logic lm,
                               logic [15:0] hi, logic [15:0] res, logic [4:0] f, int lat);
      mk = '{op: o, a: x, b: y, lm: lm, hi: hi, res: res, f: f, lat: lat};
   endfunction
   task automatic send(input vec_t v);
      int n = 0;
      while (!in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      op = v.op; a = v.a; b = v.b; lane_mode = v.lm; in_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, result, result_hi, flag_z, flag_c, flag_n, flag_v, err} !== '0)
         $display("FAIL reset_outputs: got ov=%b res=%h hi=%h zcnve=%b%b%b%b%b, need all zero",
                  out_valid, result, result_hi, flag_z, flag_c, flag_n, flag_v, err);
      else passed++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
      else passed++;
   endtask
   task automatic test_arith;
      vec_t t[19];
      vec_t e;
      int lat;
      t[0]  = mk(4'd0, 16'h09FC, 16'hAD91, 0, 16'h0, 16'hB78D, 5'b00100, 1);
      t[1]  = mk(4'd1, 16'h09FC, 16'hAD91, 0, 16'h0, 16'h5C6B, 5'b01000, 1);
      t[2]  = mk(4'd0, 16'h00FF, 16'h0001, 0, 16'h0, 16'h0100, 5'b00000, 1);
      t[3]  = mk(4'd0, 16'h00FF, 16'h0001, 1, 16'h0, 16'h0000, 5'b10000, 1);
      t[4]  = mk(4'd1, 16'h0100, 16'h0001, 1, 16'h0, 16'h01FF, 5'b00000, 1);
      t[5]  = mk(4'd0, 16'hFF00, 16'h0100, 1, 16'h0, 16'h0000, 5'b11000, 1);
      t[6]  = mk(4'd0, 16'h7FFF, 16'h0001, 0, 16'h0, 16'h8000, 5'b00110, 1);
      t[7]  = mk(4'd1, 16'h8000, 16'h0001, 0, 16'h0, 16'h7FFF, 5'b00010, 1);
      t[8]  = mk(4'd3, 16'hF0F0, 16'h0FF0, 1, 16'h0, 16'h00F0, 5'b00000, 1);
      t[9]  = mk(4'd4, 16'hF0F0, 16'h0F0F, 0, 16'h0, 16'hFFFF, 5'b00100, 1);
      t[10] = mk(4'd5, 16'hA5A5, 16'hA5A5, 0, 16'h0, 16'h0000, 5'b10000, 1);
      t[11] = mk(4'd6, 16'h00FF, 16'h1234, 0, 16'h0, 16'hFF00, 5'b00100, 1);
      t[12] = mk(4'd7, 16'h8001, 16'h0001, 0, 16'h0, 16'h0002, 5'b01000, 1);
      t[13] = mk(4'd7, 16'h1234, 16'h0000, 0, 16'h0, 16'h1234, 5'b00000, 1);
      t[14] = mk(4'd8, 16'h0003, 16'h0001, 0, 16'h0, 16'h0001, 5'b01000, 1);
      t[15] = mk(4'd9, 16'h8000, 16'h000F, 0, 16'h0, 16'hFFFF, 5'b00100, 1);
      t[16] = mk(4'd8, 16'h8000, 16'h0010, 0, 16'h0, 16'h8000, 5'b00100, 1);
      t[17] = mk(4'hF, 16'h1234, 16'h0001, 0, 16'h0, 16'h0000, 5'b00001, 1);
      t[18] = mk(4'hA, 16'h0000, 16'h0000, 1, 16'h0, 16'h0000, 5'b00001, 1);
      foreach (t[i]) begin
         send(t[i]);
         wait_out(lat);
         e = exp_q.pop_front();
         checks++;
         if ({result_hi, result, flag_z, flag_c, flag_n, flag_v, err} !== {e.hi, e.res, e.f})
            $display("FAIL arith[%0d] op=%0d: got hi=%h res=%h zcnve=%b%b%b%b%b, need hi=%h res=%h zcnve=%b",
                     i, e.op, result_hi, result, flag_z, flag_c, flag_n, flag_v, err, e.hi, e.res, e.f);
         else passed++;
         checks++;
         if (lat !== e.lat) $display("FAIL arith_latency[%0d]: got %0d need %0d", i, lat, e.lat);
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_mul;
      vec_t t[4];
      vec_t e;
      int lat, busy;
`ifdef ALU_MULT_EN
      t[0] = mk(4'd2, 16'd212, 16'd102, 0, 16'h0000, 16'h5478, 5'b00000, 17);
      t[1] = mk(4'd2, 16'hFFFF, 16'hFFFF, 0, 16'hFFFE, 16'h0001, 5'b01000, 17);
      t[2] = mk(4'd2, 16'h0000, 16'h1234, 0, 16'h0000, 16'h0000, 5'b10000, 17);
      t[3] = mk(4'd2, 16'h8000, 16'h0002, 1, 16'h0001, 16'h0000, 5'b11000, 17);
`else
      t[0] = mk(4'd2, 16'd3, 16'd4, 0, 16'h0, 16'h0, 5'b00001, 1);
      t[1] = mk(4'd2, 16'd212, 16'd102, 0, 16'h0, 16'h0, 5'b00001, 1);
      t[2] = mk(4'd2, 16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 5'b00001, 1);
      t[3] = mk(4'd2, 16'h8000, 16'h0002, 1, 16'h0, 16'h0, 5'b00001, 1);
`endif
      foreach (t[i]) begin
         send(t[i]);
         lat = 1;
         busy = 0;
         while (!out_valid && lat < 64) begin
            if (in_ready) busy++;
            @(posedge clk); #1;
            lat++;
         end
         e = exp_q.pop_front();
         checks++;
         if ({result_hi, result, flag_z, flag_c, flag_n, flag_v, err} !== {e.hi, e.res, e.f})
            $display("FAIL mul[%0d]: got hi=%h res=%h zcnve=%b%b%b%b%b, need hi=%h res=%h zcnve=%b",
                     i, result_hi, result, flag_z, flag_c, flag_n, flag_v, err, e.hi, e.res, e.f);
         else passed++;
         checks++;
         if (lat !== e.lat) $display("FAIL mul_latency[%0d]: got %0d need %0d", i, lat, e.lat);
         else passed++;
         checks++;
         if (busy !== 0) $display("FAIL mul_in_ready[%0d]: in_ready high %0d cycles, need 0", i, busy);
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_backpressure;
      vec_t e;
      int lat;
      send(mk(4'd0, 16'd1, 16'd2, 0, 16'h0, 16'h0003, 5'b00000, 1));
      wait_out(lat);
      e = exp_q.pop_front();
      out_ready = 1'b0;
      op = 4'd5; a = 16'hFFFF; b = 16'h0F0F; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, result_hi, result, flag_z, flag_c, flag_n, flag_v, err} !==
             {2'b10, e.hi, e.res, e.f})
            $display("FAIL hold[%0d]: got ov=%b ir=%b hi=%h res=%h zcnve=%b%b%b%b%b, need ov=1 ir=0 hi=%h res=%h zcnve=%b",
                     i, out_valid, in_ready, result_hi, result, flag_z, flag_c, flag_n, flag_v, err,
                     e.hi, e.res, e.f);
         else passed++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL release: got ov=%b ir=%b need ov=0 ir=1", out_valid, in_ready);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL ignored_request: got ov=%b need 0", out_valid);
      else passed++;
   endtask
   task automatic test_reset_mid;
      vec_t e;
      int lat;
`ifdef ALU_MULT_EN
      send(mk(4'd2, 16'd212, 16'd102, 0, 16'h0, 16'h5478, 5'b00000, 17));
`else
      send(mk(4'd4, 16'h8000, 16'h0001, 0, 16'h0, 16'h8001, 5'b00100, 1));
`endif
      out_ready = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      void'(exp_q.pop_front());
      checks++;
      if ({in_ready, out_valid, result, result_hi, flag_z, flag_c, flag_n, flag_v, err} !== {1'b1, 38'd0})
         $display("FAIL mid_reset: got ir=%b ov=%b res=%h hi=%h zcnve=%b%b%b%b%b, need ir=1 rest 0",
                  in_ready, out_valid, result, result_hi, flag_z, flag_c, flag_n, flag_v, err);
      else passed++;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL discarded_op: got ov=%b need 0", out_valid);
      else passed++;
      send(mk(4'd0, 16'h1234, 16'h4321, 0, 16'h0, 16'h5555, 5'b00000, 1));
      wait_out(lat);
      e = exp_q.pop_front();
      checks++;
      if ({result_hi, result, flag_z, flag_c, flag_n, flag_v, err} !== {e.hi, e.res, e.f} || lat !== e.lat)
         $display("FAIL post_reset_add: got res=%h zcnve=%b%b%b%b%b lat=%0d, need res=%h zcnve=%b lat=%0d",
                  result, flag_z, flag_c, flag_n, flag_v, err, lat, e.res, e.f, e.lat);
      else passed++;
      @(posedge clk); #1;
   endtask
   task automatic test_random;
      vec_t e, v;
      int lat;
      logic [16:0] s;
      logic [15:0] x, y, r;
      logic c, ov;
      for (int i = 0; i < 8; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         case (i % 3)
            0: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16]; ov = x[15] == y[15] && r[15] != x[15]; end
            1: begin r = x - y; c = x < y; ov = x[15] != y[15] && r[15] != x[15]; end
            default: begin r = x ^ y; c = 1'b0; ov = 1'b0; end
         endcase
         v = mk((i % 3 == 2) ? 4'd5 : 4'((i % 3)), x, y, 0, 16'h0, r, {r == 16'h0, c, r[15], ov, 1'b0}, 1);
         send(v);
         wait_out(lat);
         e = exp_q.pop_front();
         checks++;
         if ({result_hi, result, flag_z, flag_c, flag_n, flag_v, err} !== {e.hi, e.res, e.f} || lat !== e.lat)
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h zcnve=%b%b%b%b%b lat=%0d, need res=%h zcnve=%b lat=1",
                     i, e.op, e.a, e.b, result, flag_z, flag_c, flag_n, flag_v, err, lat, e.res, e.f);
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   initial begin
      test_reset();
      test_arith();
      test_mul();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
